// File: rtl/main_fsm_pkg.sv
// Shared types and constants for the start/ready sequencer.
//   state_e      : sequencer state, 2-bit encoding (2'b11 unused, recovers to StIdle)
//   OUT_W        : width of the count output
//   LAST_DEFAULT : default terminal count
package main_fsm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int unsigned OUT_W        = 5;
    localparam int unsigned LAST_DEFAULT = 31;

endpackage

// File: rtl/main_step_counter.sv
// OUT_W-bit up-counter with synchronous clear and enable.
//   clk_i  : clock, rising edge
//   clr_i  : synchronous clear to zero (wins over en_i)
//   en_i   : increment by one on the next edge
//   cnt_o  : registered count
//   last_o : high when the next increment lands on Last
module main_step_counter
    import main_fsm_pkg::*;
#(
    parameter int unsigned Last = LAST_DEFAULT
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [OUT_W-1:0] LastW = OUT_W'(Last);

    logic [OUT_W-1:0] cnt_q;
    logic [OUT_W-1:0] cnt_d;
    logic [OUT_W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + OUT_W'(1);
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_inc == LastW);

endmodule

// File: rtl/main_fsm.sv
// Start/ready sequencer. On a start request the count runs 0..LAST, one step per clock,
// then ready is raised and the final value is held until start drops.
//   clk_p : clock, all state updates on rising edge
//   reset : synchronous, active-low
//   start : level start request, only looked at in idle and done
//   out   : registered count value
//   ready : registered done flag, high only in the done state
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter int unsigned LAST = LAST_DEFAULT
) (
    input  logic             clk_p,
    input  logic             reset,
    input  logic             start,
    output logic [OUT_W-1:0] out,
    output logic             ready
);

    state_e state_q;
    state_e state_d;
    logic   ready_q;
    logic   ready_d;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_last;

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    ready_d = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            StRun: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                end
            end
            StDone: begin
                ready_d = 1'b1;
                // A held-high start keeps us here; it must drop before a new run.
                if (!start) begin
                    state_d = StIdle;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (!reset) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    main_step_counter #(
        .Last (LAST)
    ) u_counter (
        .clk_i  (clk_p),
        .clr_i  (cnt_clr | ~reset),
        .en_i   (cnt_en),
        .cnt_o  (out),
        .last_o (cnt_last)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

    logic       clk_p;
    logic       reset;
    logic       start;
    logic       start1;
    logic [4:0] out;
    logic       ready;
    logic [4:0] out1;
    logic       ready1;

    int n_checks;
    int n_errors;

    main_fsm dut (
        .clk_p (clk_p),
        .reset (reset),
        .start (start),
        .out   (out),
        .ready (ready)
    );

    main_fsm #(
        .LAST (1)
    ) dut1 (
        .clk_p (clk_p),
        .reset (reset),
        .start (start1),
        .out   (out1),
        .ready (ready1)
    );

    initial clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    task automatic step();
        @(posedge clk_p);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [4:0] exp_out, input logic exp_rdy);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_ready"}, {4'd0, ready}, {4'd0, exp_rdy});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        start    = 1'b0;
        start1   = 1'b0;

        // 1. Reset for two edges, then idle with start low.
        step();
        step();
        check_both("reset", 5'd0, 1'b0);
        check("reset_out1", out1, 5'd0);
        check("reset_ready1", {4'd0, ready1}, 5'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_both($sformatf("idle%0d", i), 5'd0, 1'b0);
        end

        // 2. Start held high: count 0..31, ready with 31. LAST=1 instance in parallel.
        start  = 1'b1;
        start1 = 1'b1;
        step();
        check_both("run1_e0", 5'd0, 1'b0);
        check("l1_e0_out", out1, 5'd0);
        check("l1_e0_ready", {4'd0, ready1}, 5'd0);
        for (int k = 1; k <= 31; k++) begin
            step();
            check_both($sformatf("run1_k%0d", k), 5'(k), k == 31);
            if (k == 1) begin
                check("l1_e1_out", out1, 5'd1);
                check("l1_e1_ready", {4'd0, ready1}, 5'd1);
            end
            if (k == 2) begin
                check("l1_hold_out", out1, 5'd1);
                check("l1_hold_ready", {4'd0, ready1}, 5'd1);
                start1 = 1'b0;
            end
            if (k == 3) begin
                check("l1_idle_out", out1, 5'd1);
                check("l1_idle_ready", {4'd0, ready1}, 5'd0);
            end
        end

        // 3. Start still high in done: no retrigger.
        for (int i = 0; i < 20; i++) begin
            step();
            check_both($sformatf("done_hold%0d", i), 5'd31, 1'b1);
        end

        // 4+6. Drop start one edge, restart, toggle start during the run.
        start = 1'b0;
        step();
        check_both("done_to_idle", 5'd31, 1'b0);
        start = 1'b1;
        step();
        check_both("run2_e0", 5'd0, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            start = k[0];
            step();
            check_both($sformatf("run2_k%0d", k), 5'(k), k == 31);
        end
        start = 1'b1;
        step();
        check_both("run2_done", 5'd31, 1'b1);

        // 5. Reset mid-run at out==12.
        start = 1'b0;
        step();
        check_both("idle2", 5'd31, 1'b0);
        start = 1'b1;
        step();
        check_both("run3_e0", 5'd0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step();
        end
        check_both("run3_k12", 5'd12, 1'b0);
        reset = 1'b0;
        step();
        check_both("mid_reset", 5'd0, 1'b0);
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_both($sformatf("post_reset%0d", i), 5'd0, 1'b0);
        end
        start = 1'b1;
        step();
        check_both("run4_e0", 5'd0, 1'b0);
        step();
        check_both("run4_k1", 5'd1, 1'b0);
        step();
        check_both("run4_k2", 5'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
